mips_multicycle_ctrl: RTL

- Control unit for the multicycle MIPS datapath.
- Sequences each instruction through fetch, decode, execute, memory and writeback states.
- Drives every datapath mux select and write enable, and generates the ALU control from opcode/funct.
- Sits inside the mips core beside the datapath; it receives op, funct and zero back from the datapath.

---
 rtl/mips_ctrl_pkg.sv | 82 ++++++++
 rtl/mips_multicycle_ctrl_if.sv | 32 +++
 rtl/mips_aludec.sv | 21 ++
 rtl/mips_multicycle_ctrl.sv | 94 +++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: shared types and constants for the multicycle MIPS control unit (HALT state exists only with MIPS_ILLEGAL_OP_TRAP_EN)
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, RTYPEWB,
        BEQEX, BNEEX, ADDIEX, ORIEX, IMMWB, JEX
`ifdef MIPS_ILLEGAL_OP_TRAP_EN
        , HALT
`endif
    } state_t;

    typedef enum logic [1:0] {ADD, SUB, FUNCT, OR} aluop_t;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef struct packed {
        logic       pcwrite;
        logic       branch;
        logic       bne;
        logic       memwrite;
        logic       irwrite;
        logic       regwrite;
        logic       iord;
        logic       memtoreg;
        logic       regdst;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic       zeroext;
        aluop_t     aluop;
`ifdef MIPS_ILLEGAL_OP_TRAP_EN
        logic       illegal;
`endif
    } ctrl_t;

    // Moore control word of a state; unlisted fields stay 0 (aluop 0 = ADD)
    function automatic ctrl_t decode(state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH:   begin c.irwrite = 1'b1; c.pcwrite = 1'b1; c.alusrcb = 2'b01; end
            DECODE:  c.alusrcb = 2'b11;
            MEMADR:  begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
            MEMRD:   c.iord = 1'b1;
            MEMWB:   begin c.memtoreg = 1'b1; c.regwrite = 1'b1; end
            MEMWR:   begin c.iord = 1'b1; c.memwrite = 1'b1; end
            RTYPEEX: begin c.alusrca = 1'b1; c.aluop = FUNCT; end
            RTYPEWB: begin c.regdst = 1'b1; c.regwrite = 1'b1; end
            BEQEX:   begin c.alusrca = 1'b1; c.aluop = SUB; c.pcsrc = 2'b01; c.branch = 1'b1; end
            BNEEX:   begin c.alusrca = 1'b1; c.aluop = SUB; c.pcsrc = 2'b01; c.bne = 1'b1; end
            ADDIEX:  begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
            ORIEX:   begin c.alusrca = 1'b1; c.alusrcb = 2'b10; c.zeroext = 1'b1; c.aluop = OR; end
            IMMWB:   c.regwrite = 1'b1;
            JEX:     begin c.pcsrc = 2'b10; c.pcwrite = 1'b1; end
`ifdef MIPS_ILLEGAL_OP_TRAP_EN
            HALT:    c.illegal = 1'b1;
`endif
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// mips_multicycle_ctrl_if: control <-> datapath bundle; master = control unit, slave = datapath
// Ports: op/funct/zero from datapath; enables, mux selects, alucontrol and illegal to datapath
interface mips_multicycle_ctrl_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       pcen;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic       iord;
    logic       memtoreg;
    logic       regdst;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic       zeroext;
    logic [2:0] alucontrol;
    logic       illegal;

    modport master (
        input  op, funct, zero,
        output pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst,
               alusrca, alusrcb, pcsrc, zeroext, alucontrol, illegal
    );

    modport slave (
        output op, funct, zero,
        input  pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst,
               alusrca, alusrcb, pcsrc, zeroext, alucontrol, illegal
    );
endinterface

// File: rtl/mips_aludec.sv
// mips_aludec: maps aluop/funct to the 3-bit ALU control (aluop, funct in; alucontrol out)
module mips_aludec
    import mips_ctrl_pkg::*;
(
    input  aluop_t     aluop,
    input  logic [5:0] funct,
    output logic [2:0] alucontrol
);
    logic [2:0] fdec;

    // unknown funct falls back to add
    always_comb begin
        fdec = funct == F_SUB ? ALU_SUB :
               funct == F_AND ? ALU_AND :
               funct == F_OR  ? ALU_OR  :
               funct == F_SLT ? ALU_SLT : ALU_ADD;
        alucontrol = aluop == SUB   ? ALU_SUB :
                     aluop == OR    ? ALU_OR  :
                     aluop == FUNCT ? fdec    : ALU_ADD;
    end
endmodule

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: multicycle MIPS control FSM with registered Moore control word
// Ports: clk, reset (sync, active low), bus (mips_multicycle_ctrl_if.master)
// Macro MIPS_ILLEGAL_OP_TRAP_EN: unsupported op traps to HALT with illegal=1
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter bit RESET_STATE_HOLD = 1'b1
)
(
    input logic clk,
    input logic reset,
    mips_multicycle_ctrl_if.master bus
);
    state_t state, nxt;
    ctrl_t  ctl, ctl_nxt, fetch_c, outc;

    always_comb begin
        nxt = FETCH;
        case (state)
            FETCH:   nxt = DECODE;
            DECODE:
                case (bus.op)
                    OP_LW, OP_SW: nxt = MEMADR;
                    OP_RTYPE:     nxt = RTYPEEX;
                    OP_BEQ:       nxt = BEQEX;
                    OP_BNE:       nxt = BNEEX;
                    OP_ADDI:      nxt = ADDIEX;
                    OP_ORI:       nxt = ORIEX;
                    OP_J:         nxt = JEX;
`ifdef MIPS_ILLEGAL_OP_TRAP_EN
                    default:      nxt = HALT;
`else
                    default:      nxt = FETCH;
`endif
                endcase
            MEMADR:  nxt = bus.op == OP_LW ? MEMRD : MEMWR;
            MEMRD:   nxt = MEMWB;
            RTYPEEX: nxt = RTYPEWB;
            ADDIEX:  nxt = IMMWB;
            ORIEX:   nxt = IMMWB;
`ifdef MIPS_ILLEGAL_OP_TRAP_EN
            HALT:    nxt = HALT;
`endif
            default: nxt = FETCH;
        endcase
    end

    // IMMWB is shared by addi/ori, so it inherits the extend mode of the execute step
    always_comb begin
        ctl_nxt = decode(nxt);
        ctl_nxt.zeroext = nxt == IMMWB ? ctl.zeroext : ctl_nxt.zeroext;
    end

    // while reset is held the outputs show FETCH, optionally with write enables suppressed
    always_comb begin
        fetch_c = decode(FETCH);
        fetch_c.irwrite = fetch_c.irwrite & ~RESET_STATE_HOLD;
        fetch_c.pcwrite = fetch_c.pcwrite & ~RESET_STATE_HOLD;
        outc = reset ? ctl : fetch_c;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= FETCH;
            ctl   <= decode(FETCH);
        end else begin
            state <= nxt;
            ctl   <= ctl_nxt;
        end
    end

    assign bus.pcen     = outc.pcwrite | (outc.branch & bus.zero) | (outc.bne & ~bus.zero);
    assign bus.memwrite = outc.memwrite;
    assign bus.irwrite  = outc.irwrite;
    assign bus.regwrite = outc.regwrite;
    assign bus.iord     = outc.iord;
    assign bus.memtoreg = outc.memtoreg;
    assign bus.regdst   = outc.regdst;
    assign bus.alusrca  = outc.alusrca;
    assign bus.alusrcb  = outc.alusrcb;
    assign bus.pcsrc    = outc.pcsrc;
    assign bus.zeroext  = outc.zeroext;
`ifdef MIPS_ILLEGAL_OP_TRAP_EN
    assign bus.illegal  = outc.illegal;
`else
    assign bus.illegal  = 1'b0;
`endif

    mips_aludec u_aludec (
        .aluop      (outc.aluop),
        .funct      (bus.funct),
        .alucontrol (bus.alucontrol)
    );
endmodule
